moxie_wb_ram: RTL and testbench

- Wishbone B3 classic slave: on-chip word-addressed RAM that answers bus cycles from the moxie core (the initiator).
- Sits in moxiesoc behind the address decode, serving code/data fetches and loads/stores.
- Configurable wait states; errors accesses outside its window instead of aliasing.
- Big-endian byte lanes, matching moxie.

---
 rtl/moxie_wb_pkg.sv | 25 ++
 rtl/moxie_bram_1p.sv | 34 +++
 rtl/moxie_wb_ram.sv | 121 ++++++++++++
 tb/tb_moxie_wb_ram.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/moxie_wb_pkg.sv
// Shared Wishbone B3 definitions for moxiesoc slaves: bus widths, FSM
// state encodings and the big-endian byte-lane mapping.
package moxie_wb_pkg;

  localparam int WB_AW   = 32;
  localparam int WB_DW   = 32;
  localparam int WB_SELW = 4;
  localparam int BYTE_W  = 8;

  // Big-endian lanes: sel[3] carries data[31:24], the lowest byte address.
  localparam int LANE_LOW_ADDR  = 3;
  localparam int LANE_HIGH_ADDR = 0;

  typedef logic [1:0] wb_state_t;

  localparam wb_state_t S_IDLE = 2'd0;
  localparam wb_state_t S_WAIT = 2'd1;
  localparam wb_state_t S_RESP = 2'd2;

  // Least significant data bit carried by a given sel lane.
  function automatic int laneLsb(input int lane);
    return lane * BYTE_W;
  endfunction

endpackage

// File: rtl/moxie_bram_1p.sv
// Single-port synchronous RAM with per-byte write enables and a registered
// read port. Kept free of resets so the array maps onto block RAM.
module moxie_bram_1p
  import moxie_wb_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic               i_clk,
  input  logic               i_re,
  input  logic [WB_SELW-1:0] i_we,
  input  logic [IDX_W-1:0]   i_idx,
  input  logic [WB_DW-1:0]   i_wdat,
  output logic [WB_DW-1:0]   o_rdat
);

  logic [WB_DW-1:0] r_mem [DEPTH_WORDS];
  logic [WB_DW-1:0] r_rdat;

  // Byte-lane writes and registered read; the read register only moves on i_re.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < WB_SELW; b++) begin
      if (i_we[b]) begin
        r_mem[i_idx][laneLsb(b) +: BYTE_W] <= i_wdat[laneLsb(b) +: BYTE_W];
      end
    end
    if (i_re) begin
      r_rdat <= r_mem[i_idx];
    end
  end

  assign o_rdat = r_rdat;

endmodule

// File: rtl/moxie_wb_ram.sv
// Wishbone B3 classic slave wrapping an on-chip word RAM for the moxie core.
// Accesses outside the window terminate with err instead of aliasing, and an
// optional number of wait states is inserted before every response.
module moxie_wb_ram
  import moxie_wb_pkg::*;
#(
  parameter logic [WB_AW-1:0] ADDR_BASE   = 32'h0000_0000,
  parameter int               DEPTH_WORDS = 1024,
  parameter int               WAIT_STATES = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [WB_AW-1:0]   wb_adr_i,
  input  logic [WB_SELW-1:0] wb_sel_i,
  input  logic [WB_DW-1:0]   wb_dat_i,
  output logic [WB_DW-1:0]   wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_err_o
);

  localparam int              IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [WB_AW-1:0] LIMIT    = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]      CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic            NO_WAIT  = (WAIT_STATES == 0);

  wb_state_t r_state;
  logic [3:0] r_cnt;
  logic       r_ack;
  logic       r_err;
  logic       r_datZero;

  logic [WB_AW-1:0]   w_off;
  logic               w_inRange;
  logic [IDX_W-1:0]   w_idx;
  logic               w_req;
  logic               w_enterResp;
  logic               w_re;
  logic [WB_SELW-1:0] w_we;
  logic [WB_DW-1:0]   w_rdat;

  // Address decode is a wrapping subtract, so addresses below the base land
  // far above the limit and are rejected rather than aliased.
  assign w_off     = wb_adr_i - ADDR_BASE;
  assign w_inRange = (w_off < LIMIT);
  assign w_idx     = w_off[IDX_W+1:2];
  assign w_req     = wb_cyc_i & wb_stb_i;

  // The access happens on the edge entering RESP, using the bus as sampled there.
  assign w_enterResp = w_req & (((r_state == S_IDLE) & NO_WAIT) |
                                ((r_state == S_WAIT) & (r_cnt == 4'd0)));
  assign w_re = w_enterResp & w_inRange & ~wb_we_i;
  assign w_we = (w_enterResp & w_inRange & wb_we_i) ? wb_sel_i : '0;

  moxie_bram_1p #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_bram (
    .i_clk  (clk_i),
    .i_re   (w_re),
    .i_we   (w_we),
    .i_idx  (w_idx),
    .i_wdat (wb_dat_i),
    .o_rdat (w_rdat)
  );

  // Transfer FSM plus response flags; r_datZero masks read data after reset or err.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_datZero <= 1'b1;
    end else begin
      r_ack <= w_enterResp & w_inRange;
      r_err <= w_enterResp & ~w_inRange;
      if (w_enterResp) begin
        if (!w_inRange) begin
          r_datZero <= 1'b1;
        end else if (!wb_we_i) begin
          r_datZero <= 1'b0;
        end
      end
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (NO_WAIT) begin
              r_state <= S_RESP;
            end else begin
              r_cnt   <= CNT_INIT;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!w_req) begin
            r_state <= S_IDLE;
          end else if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign wb_dat_o = r_datZero ? '0 : w_rdat;
  assign wb_ack_o = r_ack;
  assign wb_err_o = r_err;

endmodule

// File: tb/tb_moxie_wb_ram.sv
// Directed testbench for moxie_wb_ram: three instances with 0, 2 and 3 wait
// states sharing one clock and reset.
module tb_moxie_wb_ram;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 16;

  logic clk;
  logic rst_n;

  logic [2:0]       cycV, stbV, weV;
  logic [2:0][31:0] adrV, datiV, datoV;
  logic [2:0][3:0]  selV;
  logic [2:0]       ackV, errV;

  int nCompared;
  int nMismatched;

  moxie_wb_ram #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk_i(clk), .rst_i(rst_n), .wb_cyc_i(cycV[0]), .wb_stb_i(stbV[0]),
    .wb_we_i(weV[0]), .wb_adr_i(adrV[0]), .wb_sel_i(selV[0]), .wb_dat_i(datiV[0]),
    .wb_dat_o(datoV[0]), .wb_ack_o(ackV[0]), .wb_err_o(errV[0]));

  moxie_wb_ram #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) dut2 (
    .clk_i(clk), .rst_i(rst_n), .wb_cyc_i(cycV[1]), .wb_stb_i(stbV[1]),
    .wb_we_i(weV[1]), .wb_adr_i(adrV[1]), .wb_sel_i(selV[1]), .wb_dat_i(datiV[1]),
    .wb_dat_o(datoV[1]), .wb_ack_o(ackV[1]), .wb_err_o(errV[1]));

  moxie_wb_ram #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) dut3 (
    .clk_i(clk), .rst_i(rst_n), .wb_cyc_i(cycV[2]), .wb_stb_i(stbV[2]),
    .wb_we_i(weV[2]), .wb_adr_i(adrV[2]), .wb_sel_i(selV[2]), .wb_dat_i(datiV[2]),
    .wb_dat_o(datoV[2]), .wb_ack_o(ackV[2]), .wb_err_o(errV[2]));

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a handshake never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // One transfer on instance d; lat counts rising edges from the request edge
  // until a response is visible (41 means no response within the budget).
  task automatic doXfer(input int d, input logic we, input logic [31:0] adr,
                        input logic [3:0] sel, input logic [31:0] wdat,
                        output int lat, output logic ack, output logic err,
                        output logic [31:0] dat);
    @(negedge clk);
    cycV[d] = 1'b1; stbV[d] = 1'b1; weV[d] = we;
    adrV[d] = adr; selV[d] = sel; datiV[d] = wdat;
    lat = 41; ack = 1'b0; err = 1'b0; dat = 32'h0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ackV[d] || errV[d]) begin
        lat = i; ack = ackV[d]; err = errV[d]; dat = datoV[d];
        break;
      end
    end
    cycV[d] = 1'b0; stbV[d] = 1'b0; weV[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycV = '0; stbV = '0; weV = '0; adrV = '0; datiV = '0; selV = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      nCompared++;
      if (ackV[d] !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_ack[%0d]: got %b expected 0", d, ackV[d]); end
      nCompared++;
      if (errV[d] !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_err[%0d]: got %b expected 0", d, errV[d]); end
      nCompared++;
      if (datoV[d] !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_dat[%0d]: got %h expected 00000000", d, datoV[d]); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_wait0();
    int lat; logic ack, err; logic [31:0] dat;
    doXfer(0, 1'b1, BASE + 32'h10, 4'hF, 32'hDEADBEEF, lat, ack, err, dat);
    nCompared++;
    if (lat !== 1) begin nMismatched++; $display("[TB] FAIL ws0_write_lat: got %0d expected 1", lat); end
    nCompared++;
    if (ack !== 1'b1 || err !== 1'b0) begin nMismatched++; $display("[TB] FAIL ws0_write_resp: got ack=%b err=%b expected ack=1 err=0", ack, err); end
    @(negedge clk);
    nCompared++;
    if (ackV[0] !== 1'b0) begin nMismatched++; $display("[TB] FAIL ws0_ack_pulse: got %b expected 0", ackV[0]); end
    doXfer(0, 1'b0, BASE + 32'h10, 4'h0, 32'h0, lat, ack, err, dat);
    nCompared++;
    if (lat !== 1) begin nMismatched++; $display("[TB] FAIL ws0_read_lat: got %0d expected 1", lat); end
    nCompared++;
    if (dat !== 32'hDEADBEEF) begin nMismatched++; $display("[TB] FAIL ws0_read_dat: got %h expected deadbeef", dat); end
  endtask

  task automatic test_byte_lanes();
    int lat; logic ack, err; logic [31:0] dat;
    doXfer(0, 1'b1, BASE + 32'h18, 4'hF, 32'h11223344, lat, ack, err, dat);
    doXfer(0, 1'b1, BASE + 32'h18, 4'b0100, 32'hAABBCCDD, lat, ack, err, dat);
    doXfer(0, 1'b0, BASE + 32'h18, 4'hF, 32'h0, lat, ack, err, dat);
    nCompared++;
    if (dat !== 32'h11BB3344) begin nMismatched++; $display("[TB] FAIL lane_sel0100: got %h expected 11bb3344", dat); end
    doXfer(0, 1'b1, BASE + 32'h18, 4'b0000, 32'h55667788, lat, ack, err, dat);
    nCompared++;
    if (ack !== 1'b1 || err !== 1'b0) begin nMismatched++; $display("[TB] FAIL lane_sel0000_ack: got ack=%b err=%b expected ack=1 err=0", ack, err); end
    doXfer(0, 1'b0, BASE + 32'h18, 4'b0001, 32'h0, lat, ack, err, dat);
    nCompared++;
    if (dat !== 32'h11BB3344) begin nMismatched++; $display("[TB] FAIL lane_sel0000_keep: got %h expected 11bb3344", dat); end
  endtask

  task automatic test_wait3();
    int lat; int firstAck; logic ack, err; logic [31:0] dat;
    doXfer(2, 1'b1, BASE + 32'h04, 4'hF, 32'h0F0F1234, lat, ack, err, dat);
    nCompared++;
    if (lat !== 4) begin nMismatched++; $display("[TB] FAIL ws3_write_lat: got %0d expected 4", lat); end
    // Read with stb held through ack.
    @(negedge clk);
    cycV[2] = 1'b1; stbV[2] = 1'b1; weV[2] = 1'b0; adrV[2] = BASE + 32'h04; selV[2] = 4'hF;
    firstAck = 0; dat = 32'h0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ackV[2]) begin firstAck = i; dat = datoV[2]; break; end
    end
    nCompared++;
    if (firstAck !== 4) begin nMismatched++; $display("[TB] FAIL ws3_read_lat: got %0d expected 4", firstAck); end
    nCompared++;
    if (dat !== 32'h0F0F1234) begin nMismatched++; $display("[TB] FAIL ws3_read_dat: got %h expected 0f0f1234", dat); end
    @(posedge clk);
    @(negedge clk);
    nCompared++;
    if (ackV[2] !== 1'b0) begin nMismatched++; $display("[TB] FAIL ws3_no_double_ack: got %b expected 0", ackV[2]); end
    cycV[2] = 1'b0; stbV[2] = 1'b0;
  endtask

  task automatic test_out_of_range();
    int lat; logic ack, err; logic [31:0] dat;
    doXfer(0, 1'b1, BASE, 4'hF, 32'h0BADF00D, lat, ack, err, dat);
    doXfer(0, 1'b1, BASE + 32'h3C, 4'hF, 32'h15151515, lat, ack, err, dat);
    doXfer(0, 1'b0, BASE, 4'hF, 32'h0, lat, ack, err, dat);
    doXfer(0, 1'b0, BASE + 32'h40, 4'hF, 32'h0, lat, ack, err, dat);
    nCompared++;
    if (err !== 1'b1 || ack !== 1'b0) begin nMismatched++; $display("[TB] FAIL oor_read_resp: got ack=%b err=%b expected ack=0 err=1", ack, err); end
    nCompared++;
    if (dat !== 32'h0) begin nMismatched++; $display("[TB] FAIL oor_read_dat: got %h expected 00000000", dat); end
    doXfer(0, 1'b1, BASE - 32'h4, 4'hF, 32'hFFFFFFFF, lat, ack, err, dat);
    nCompared++;
    if (err !== 1'b1 || ack !== 1'b0) begin nMismatched++; $display("[TB] FAIL oor_write_resp: got ack=%b err=%b expected ack=0 err=1", ack, err); end
    doXfer(0, 1'b0, BASE, 4'hF, 32'h0, lat, ack, err, dat);
    nCompared++;
    if (dat !== 32'h0BADF00D) begin nMismatched++; $display("[TB] FAIL oor_word0_kept: got %h expected 0badf00d", dat); end
    doXfer(0, 1'b0, BASE + 32'h3C, 4'hF, 32'h0, lat, ack, err, dat);
    nCompared++;
    if (dat !== 32'h15151515) begin nMismatched++; $display("[TB] FAIL oor_word15_kept: got %h expected 15151515", dat); end
  endtask

  task automatic test_abort();
    int lat; logic ack, err; logic [31:0] dat; logic sawResp;
    doXfer(1, 1'b1, BASE + 32'h20, 4'hF, 32'hCAFEF00D, lat, ack, err, dat);
    nCompared++;
    if (lat !== 3) begin nMismatched++; $display("[TB] FAIL ws2_write_lat: got %0d expected 3", lat); end
    @(negedge clk);
    cycV[1] = 1'b1; stbV[1] = 1'b1; weV[1] = 1'b1; adrV[1] = BASE + 32'h20;
    selV[1] = 4'hF; datiV[1] = 32'h12345678;
    sawResp = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      sawResp = sawResp | ackV[1] | errV[1];
    end
    cycV[1] = 1'b0; stbV[1] = 1'b0; weV[1] = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      sawResp = sawResp | ackV[1] | errV[1];
    end
    nCompared++;
    if (sawResp !== 1'b0) begin nMismatched++; $display("[TB] FAIL abort_no_resp: got %b expected 0", sawResp); end
    doXfer(1, 1'b0, BASE + 32'h20, 4'hF, 32'h0, lat, ack, err, dat);
    nCompared++;
    if (dat !== 32'hCAFEF00D) begin nMismatched++; $display("[TB] FAIL abort_no_write: got %h expected cafef00d", dat); end
  endtask

  task automatic test_reset_midwait();
    int lat; logic ack, err; logic [31:0] dat;
    doXfer(1, 1'b0, BASE + 32'h20, 4'hF, 32'h0, lat, ack, err, dat);
    @(negedge clk);
    cycV[1] = 1'b1; stbV[1] = 1'b1; weV[1] = 1'b1; adrV[1] = BASE + 32'h20;
    selV[1] = 4'hF; datiV[1] = 32'h77777777;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    nCompared++;
    if (ackV[1] !== 1'b0 || errV[1] !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_mid_resp: got ack=%b err=%b expected 0 0", ackV[1], errV[1]); end
    nCompared++;
    if (datoV[1] !== 32'h0) begin nMismatched++; $display("[TB] FAIL rst_mid_dat: got %h expected 00000000", datoV[1]); end
    cycV[1] = 1'b0; stbV[1] = 1'b0; weV[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    doXfer(1, 1'b0, BASE + 32'h20, 4'hF, 32'h0, lat, ack, err, dat);
    nCompared++;
    if (lat !== 3 || ack !== 1'b1) begin nMismatched++; $display("[TB] FAIL rst_after_read: got lat=%0d ack=%b expected lat=3 ack=1", lat, ack); end
    nCompared++;
    if (dat !== 32'hCAFEF00D) begin nMismatched++; $display("[TB] FAIL rst_write_lost: got %h expected cafef00d", dat); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    nCompared = 0;
    nMismatched = 0;
    test_reset();
    test_wait0();
    test_byte_lanes();
    test_wait3();
    test_out_of_range();
    test_abort();
    test_reset_midwait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
